// File: rtl/fpadd_sched_pkg.sv
// Shared types and width helpers for the fpadd_scheduler slice.
//
// Contents:
//   FP_W, OVF_W    operand/result width and adder overflow-flag width
//   fp_t, ovf_t    matching logic vector typedefs
//   id_width()     index width for an N-entry set (never less than 1)
//   cnt_width()    width able to hold the values 0..N inclusive
//
// The response record {id, z, ovf} depends on the requester count, so it is
// declared inside fpadd_scheduler where that parameter is known.
package fpadd_sched_pkg;

    localparam int FP_W  = 32;
    localparam int OVF_W = 2;

    typedef logic [FP_W-1:0]  fp_t;
    typedef logic [OVF_W-1:0] ovf_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fpadd_scheduler_rr_arbiter.sv
// rr_arbiter: N-wide rotating-priority arbiter with a global enable.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       synchronous reset, active-low (pointer returns to 0)
//   en_i         allow a grant this cycle
//   req_i        request vector
//   gnt_o        one-hot grant (combinational)
//   gnt_valid_o  a grant is being given this cycle
//   gnt_idx_o    index of the granted requester
//
// Search order is ptr, ptr+1, ... wrapping at N. After a grant to i the
// pointer moves to i+1 so the winner becomes lowest priority next time.
module rr_arbiter
    import fpadd_sched_pkg::*;
#(
    parameter int  N     = 4,
    localparam int IDX_W = id_width(N)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     gnt_o,
    output logic             gnt_valid_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W:0]   cand;

    // Walk the priority order from lowest to highest priority so the last
    // hit (highest priority) is the one that sticks.
    always_comb begin
        gnt_o       = '0;
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        cand        = '0;
        if (en_i) begin
            for (int k = N - 1; k >= 0; k--) begin
                cand = {1'b0, ptr_q} + (IDX_W + 1)'(k);
                if (cand >= (IDX_W + 1)'(N)) begin
                    cand = cand - (IDX_W + 1)'(N);
                end
                if (req_i[cand[IDX_W-1:0]]) begin
                    gnt_valid_o = 1'b1;
                    gnt_idx_o   = cand[IDX_W-1:0];
                end
            end
        end
        if (gnt_valid_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_valid_o) begin
            ptr_d = (gnt_idx_o == IDX_W'(N - 1)) ? '0 : gnt_idx_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fpadd_scheduler.sv
// fpadd_scheduler: shares one pipelined floating-point adder among NREQ
// requesters. Requests are arbitrated round-robin, each issued operation
// carries its requester index down a tag pipe that tracks the adder
// latency, and results land in a small FIFO. Issue is credit-protected so
// the non-stallable adder can never overrun the FIFO.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-low
//   req_valid  [NREQ]        request per requester
//   req_ready  [NREQ]        one-hot grant (combinational)
//   req_x/y    [NREQ*32]     operands, requester i at bits [32*i +: 32]
//   add_x/y    [32]          registered operands to the adder
//   add_z      [32]          adder result
//   add_ovf    [2]           adder overflow flags
//   rsp_valid               FIFO head valid
//   rsp_ready               consumer accepts head
//   rsp_id     [ID_W]        requester index of head
//   rsp_z      [32]          head result
//   rsp_ovf    [2]           head overflow flags
//   busy                    op in flight or FIFO non-empty
module fpadd_scheduler
    import fpadd_sched_pkg::*;
#(
    parameter int  NREQ      = 4,
    parameter int  ADD_LAT   = 3,
    parameter int  RSP_DEPTH = 4,
    localparam int ID_W      = id_width(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*FP_W-1:0] req_x,
    input  logic [NREQ*FP_W-1:0] req_y,
    output logic [FP_W-1:0]      add_x,
    output logic [FP_W-1:0]      add_y,
    input  logic [FP_W-1:0]      add_z,
    input  logic [OVF_W-1:0]     add_ovf,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [FP_W-1:0]      rsp_z,
    output logic [OVF_W-1:0]     rsp_ovf,
    output logic                 busy
);

    localparam int CNT_W  = cnt_width(RSP_DEPTH);
    localparam int PTR_W  = id_width(RSP_DEPTH);
    // One stage for the operand register plus ADD_LAT adder stages.
    localparam int STAGES = ADD_LAT + 1;

    typedef struct packed {
        logic [ID_W-1:0] id;
        fp_t             z;
        ovf_t            ovf;
    } rsp_t;

    // ------------------------------------------------------------------
    // Operand unpacking
    // ------------------------------------------------------------------
    fp_t req_x_arr [NREQ];
    fp_t req_y_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_x_arr[gi] = req_x[gi*FP_W +: FP_W];
            assign req_y_arr[gi] = req_y[gi*FP_W +: FP_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Arbitration and issue
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] credit_q;
    logic [CNT_W-1:0] credit_d;
    logic             arb_en;
    logic             issue;
    logic [ID_W-1:0]  issue_id;
    logic [NREQ-1:0]  gnt;

    // No grants while held in reset or when every FIFO slot is spoken for.
    assign arb_en = rst && (credit_q != '0);

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk_i       (clk),
        .rst_ni      (rst),
        .en_i        (arb_en),
        .req_i       (req_valid),
        .gnt_o       (gnt),
        .gnt_valid_o (issue),
        .gnt_idx_o   (issue_id)
    );

    // The arbiter only grants asserted requests, so a grant is a handshake.
    assign req_ready = gnt;

    fp_t add_x_q;
    fp_t add_y_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            add_x_q <= '0;
            add_y_q <= '0;
        end else if (issue) begin
            add_x_q <= req_x_arr[issue_id];
            add_y_q <= req_y_arr[issue_id];
        end
    end

    assign add_x = add_x_q;
    assign add_y = add_y_q;

    // ------------------------------------------------------------------
    // Tag pipe: the last stage lines up with add_z/add_ovf of the same op
    // ------------------------------------------------------------------
    logic [STAGES-1:0] tag_valid_q;
    logic [ID_W-1:0]   tag_id_q [STAGES];

    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_valid_q <= '0;
        end else begin
            tag_valid_q <= {tag_valid_q[STAGES-2:0], issue};
        end
    end

    // Ids only matter where the matching valid bit is set.
    always_ff @(posedge clk) begin
        tag_id_q[0] <= issue_id;
        for (int s = 1; s < STAGES; s++) begin
            tag_id_q[s] <= tag_id_q[s-1];
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    rsp_t             fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push;
    logic             pop;
    rsp_t             head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push      = tag_valid_q[STAGES-1];
    assign rsp_valid = rst && (count_q != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign head      = fifo_mem[rd_ptr_q];

    assign rsp_id  = head.id;
    assign rsp_z   = head.z;
    assign rsp_ovf = head.ovf;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{id: tag_id_q[STAGES-1], z: add_z, ovf: add_ovf};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        credit_d = credit_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A credit is held from issue until the result leaves the FIFO.
        case ({issue, pop})
            2'b10:   credit_d = credit_q - CNT_W'(1);
            2'b01:   credit_d = credit_q + CNT_W'(1);
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            credit_q <= CNT_W'(RSP_DEPTH);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            credit_q <= credit_d;
        end
    end

    // Credits make a push into a full FIFO unreachable; catch it if not.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_no_overflow: assert (!(push && !pop && (count_q == CNT_W'(RSP_DEPTH))));
        end
    end

    assign busy = rst && ((|tag_valid_q) || (count_q != '0));

endmodule

// File: tb/tb_fpadd_scheduler.sv
module tb_fpadd_scheduler;

    localparam int NREQ      = 4;
    localparam int ADD_LAT   = 3;
    localparam int RSP_DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [127:0]  req_x;
    logic [127:0]  req_y;
    logic [31:0]   add_x;
    logic [31:0]   add_y;
    logic [31:0]   add_z;
    logic [1:0]    add_ovf;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [31:0]   rsp_z;
    logic [1:0]    rsp_ovf;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    fpadd_scheduler #(
        .NREQ      (NREQ),
        .ADD_LAT   (ADD_LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .add_x     (add_x),
        .add_y     (add_y),
        .add_z     (add_z),
        .add_ovf   (add_ovf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    // Positive-operand float adder, truncating. Result is {inexact, overflow, z}.
    function automatic logic [33:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  ea, eb, e;
        logic [24:0] ma, mb, s;
        int          sh;
        logic        inexact, ofl;
        logic [31:0] z;
        ea = a[30:23];
        eb = b[30:23];
        ma = {2'b01, a[22:0]};
        mb = {2'b01, b[22:0]};
        if (eb > ea) begin
            e = ea; ea = eb; eb = e;
            s = ma; ma = mb; mb = s;
        end
        sh = int'(ea) - int'(eb);
        if (sh > 24) begin
            inexact = 1'b1;
            mb = '0;
        end else begin
            inexact = (mb & ((25'd1 << sh) - 25'd1)) != 25'd0;
            mb = mb >> sh;
        end
        s = ma + mb;
        e = ea;
        if (s[24]) begin
            inexact = inexact | s[0];
            s = s >> 1;
            e = e + 8'd1;
        end
        ofl = (e == 8'hFF);
        z = ofl ? 32'h7F800000 : {1'b0, e, s[22:0]};
        return {inexact, ofl, z};
    endfunction

    // Adder stand-in: ADD_LAT cycles from add_x/add_y to add_z/add_ovf.
    logic [33:0] fa_pipe [ADD_LAT];
    always @(posedge clk) begin
        fa_pipe[0] <= fp_add(add_x, add_y);
        for (int k = 1; k < ADD_LAT; k++) fa_pipe[k] <= fa_pipe[k-1];
    end
    assign add_z   = fa_pipe[ADD_LAT-1][31:0];
    assign add_ovf = fa_pipe[ADD_LAT-1][33:32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          id;
        logic [31:0] z;
        logic [1:0]  ovf;
        int          due;
    } exp_t;

    exp_t        mq[$];
    int          m_ptr = 0;
    int          m_credit = RSP_DEPTH;
    int          gnt_log[$];
    int          rsp_id_log[$];
    logic [31:0] rsp_z_log[$];

    always @(negedge clk) begin : cmp
        logic [3:0]  exp_ready;
        logic        exp_valid;
        logic [33:0] r;
        int          g;
        int          idx;
        exp_ready = '0;
        g = -1;
        if (!rst) begin
            chk("rst_req_ready", 64'(req_ready), 64'(0));
            chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            mq.delete();
            m_ptr = 0;
            m_credit = RSP_DEPTH;
        end else begin
            if (m_credit > 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    idx = (m_ptr + k) % NREQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            if (g >= 0) exp_ready[g] = 1'b1;
            exp_valid = (mq.size() > 0) && (cyc >= mq[0].due);
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
            chk("busy", 64'(busy), 64'(mq.size() > 0));
            if (exp_valid) begin
                chk("rsp_id", 64'(rsp_id), 64'(mq[0].id));
                chk("rsp_z", 64'(rsp_z), 64'(mq[0].z));
                chk("rsp_ovf", 64'(rsp_ovf), 64'(mq[0].ovf));
            end
            for (int k = 0; k < NREQ; k++) if (req_ready[k]) gnt_log.push_back(k);
            if (rsp_valid && rsp_ready) begin
                rsp_id_log.push_back(int'(rsp_id));
                rsp_z_log.push_back(rsp_z);
                $display("rsp cycle=%0d id=%0d z=%08h ovf=%b", cyc, rsp_id, rsp_z, rsp_ovf);
            end
            if (exp_valid && rsp_ready) begin
                void'(mq.pop_front());
                m_credit++;
            end
            if (g >= 0) begin
                r = fp_add(req_x[g*32 +: 32], req_y[g*32 +: 32]);
                mq.push_back('{g, r[31:0], r[33:32], cyc + ADD_LAT + 2});
                m_ptr = (g + 1) % NREQ;
                m_credit--;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y);
        req_x[i*32 +: 32] = x;
        req_y[i*32 +: 32] = y;
    endtask

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        if ($urandom_range(0, 15) == 0) e = 8'($urandom_range(250, 254));
        else e = 8'($urandom_range(120, 135));
        return {1'b0, e, 23'($urandom)};
    endfunction

    task automatic rand_operands();
        for (int i = 0; i < NREQ; i++) set_req(i, rand_fp(), rand_fp());
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 60);
        chk(name, 64'(busy), 64'(0));
        step();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        rst = 1'b0;
        req_valid = '0;
        req_x = '0;
        req_y = '0;
        rsp_ready = 1'b1;

        // Pin the adder model with hand-worked sums.
        chk("model_pin_t1", 64'(fp_add(32'h4F800002, 32'h4F800004)), 64'({2'b00, 32'h50000003}));
        chk("model_pin_one", 64'(fp_add(32'h3F800000, 32'h3F800000)), 64'({2'b00, 32'h40000000}));
        chk("model_pin_ofl", 64'(fp_add(32'h7F000000, 32'h7F000000)), 64'({2'b01, 32'h7F800000}));

        repeat (3) step();
        rst = 1'b1;
        step();

        // 1. Single op latency and value.
        set_req(0, 32'h4F800002, 32'h4F800004);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t1_grant", 64'(req_ready), 64'(4'b0001));
        step();
        req_valid = '0;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (rsp_valid) break;
        end
        chk("t1_latency", 64'(n), 64'(5));
        chk("t1_id", 64'(rsp_id), 64'(0));
        chk("t1_z", 64'(rsp_z), 64'(32'h50000003));
        chk("t1_ovf", 64'(rsp_ovf), 64'(0));
        step();
        wait_idle("t1_idle");

        // 2. All requesters valid, pointer from 0.
        rst = 1'b0;
        step();
        rst = 1'b1;
        gnt_log.delete();
        rsp_id_log.delete();
        req_valid = 4'hF;
        for (int c = 0; c < 24; c++) begin
            rand_operands();
            step();
        end
        req_valid = '0;
        wait_idle("t2_idle");
        chk("t2_rsp_count", 64'(rsp_id_log.size()), 64'(gnt_log.size()));
        for (int k = 0; k < gnt_log.size(); k++) chk("t2_grant_order", 64'(gnt_log[k]), 64'(k % 4));
        for (int k = 0; k < rsp_id_log.size(); k++) chk("t2_rsp_order", 64'(rsp_id_log[k]), 64'(k % 4));

        // 3. Backpressure: exactly RSP_DEPTH grants.
        rsp_ready = 1'b0;
        set_req(1, 32'h3F800000, 32'h3F800000);
        req_valid = 4'b0010;
        gnt_log.delete();
        repeat (12) step();
        chk("t3_grants", 64'(gnt_log.size()), 64'(4));
        @(negedge clk);
        chk("t3_ready_low", 64'(req_ready), 64'(0));
        step();

        // 4. One pop on a full FIFO frees exactly one credit.
        gnt_log.delete();
        rsp_z_log.delete();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        repeat (10) step();
        chk("t4_one_grant", 64'(gnt_log.size()), 64'(1));
        chk("t4_one_pop", 64'(rsp_z_log.size()), 64'(1));
        gnt_log.delete();
        rsp_z_log.delete();
        rsp_ready = 1'b1;
        repeat (4) step();
        chk("t4_drain_count", 64'(rsp_z_log.size()), 64'(4));
        for (int k = 0; k < rsp_z_log.size(); k++) chk("t4_drain_z", 64'(rsp_z_log[k]), 64'(32'h40000000));
        chk("t4_resume", 64'(gnt_log.size() != 0), 64'(1));
        req_valid = '0;
        wait_idle("t4_idle");

        // 5. Reset with three ops in flight.
        set_req(0, 32'h3F800000, 32'h40000000);
        req_valid = 4'b0001;
        repeat (3) step();
        req_valid = '0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        rsp_z_log.delete();
        repeat (10) step();
        chk("t5_no_stale", 64'(rsp_z_log.size()), 64'(0));
        @(negedge clk);
        chk("t5_busy", 64'(busy), 64'(0));
        step();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        gnt_log.delete();
        @(negedge clk);
        chk("t5_first_grant", 64'(req_ready), 64'(4'b0001));
        step();
        repeat (7) step();
        chk("t5_credit", 64'(gnt_log.size()), 64'(4));
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle("t5_idle");

        // 6. Pointer fairness after a grant to 3.
        gnt_log.delete();
        req_valid = 4'b1000;
        step();
        req_valid = 4'b1100;
        step();
        req_valid = 4'b1000;
        repeat (2) step();
        req_valid = '0;
        chk("t6_count", 64'(gnt_log.size()), 64'(4));
        if (gnt_log.size() == 4) begin
            chk("t6_g0", 64'(gnt_log[0]), 64'(3));
            chk("t6_g1", 64'(gnt_log[1]), 64'(2));
            chk("t6_g2", 64'(gnt_log[2]), 64'(3));
            chk("t6_g3", 64'(gnt_log[3]), 64'(3));
        end
        wait_idle("t6_idle");

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) != 0);
            rand_operands();
            step();
        end
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle("rand_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
